barrel_shifter32: RTL and testbench

32-bit four-mode barrel shifter with a registered result, used as the shift unit beside the ALU in the single-cycle/pipelined CPU datapath. It shifts a 32-bit operand by 0–31 positions. The shift mode is arithmetic right, logical right, arithmetic left or logical left. The result is registered on the single system clock and cleared by an asynchronous active-low reset.

---
 rtl/barrel_shifter32_if.sv | 11 +
 rtl/barrel_shifter32.sv | 53 +++++
 tb/tb_barrel_shifter32.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/barrel_shifter32_if.sv
// Operand, amount, mode and registered result of the 32-bit shift unit,
// grouped so the datapath can hand the shifter a single bundle.
interface barrel_shifter32_if;
  logic [31:0] a;
  logic [4:0]  b;
  logic [1:0]  aluc;
  logic [31:0] c;

  modport master (output a, output b, output aluc, input c);
  modport slave  (input a, input b, input aluc, output c);
endinterface

// File: rtl/barrel_shifter32.sv
// Four-mode 32-bit logarithmic barrel shifter (SRA/SRL/SLA/SLL) with a
// registered result; one result per cycle, one cycle of latency.
module barrel_shifter32 (
  input  logic                clk,
  input  logic                rst_n,
  barrel_shifter32_if.slave   bus
);

  localparam logic [1:0] MODE_SRA = 2'b00;

  logic        shift_right;
  logic        fill;
  logic [31:0] s1, s2, s4, s8, s16;
  logic [31:0] c_d;
  logic [31:0] c_q;

  // aluc[1] low selects the right shifts; only SRA replicates the sign bit.
  always_comb begin
    shift_right = ~bus.aluc[1];
    fill        = (bus.aluc == MODE_SRA) & bus.a[31];

    s1 = bus.a;
    if (bus.b[0])
      s1 = shift_right ? {fill, bus.a[31:1]} : {bus.a[30:0], 1'b0};

    s2 = s1;
    if (bus.b[1])
      s2 = shift_right ? {{2{fill}}, s1[31:2]} : {s1[29:0], 2'b0};

    s4 = s2;
    if (bus.b[2])
      s4 = shift_right ? {{4{fill}}, s2[31:4]} : {s2[27:0], 4'b0};

    s8 = s4;
    if (bus.b[3])
      s8 = shift_right ? {{8{fill}}, s4[31:8]} : {s4[23:0], 8'b0};

    s16 = s8;
    if (bus.b[4])
      s16 = shift_right ? {{16{fill}}, s8[31:16]} : {s8[15:0], 16'b0};

    c_d = s16;
  end

  // Output register: the only state in the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) c_q <= 32'h0000_0000;
    else        c_q <= c_d;
  end

  assign bus.c = c_q;

endmodule

// File: tb/tb_barrel_shifter32.sv
// Directed-vector bench for barrel_shifter32: table of hand-computed
// results plus reset, back-to-back and mid-stream reset sequences.
module tb_barrel_shifter32;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  b;
    logic [1:0]  aluc;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];

  barrel_shifter32_if bus ();

  barrel_shifter32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic addv(input logic [31:0] a, input logic [4:0] b, input logic [1:0] aluc,
                      input logic [31:0] exp, input string name);
    vec_t v;
    v.a = a; v.b = b; v.aluc = aluc; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [31:0] a, input logic [4:0] b, input logic [1:0] aluc);
    bus.a = a; bus.b = b; bus.aluc = aluc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    addv(32'h8000_0000, 5'd4,  2'b00, 32'hF800_0000, "sra_8000_b4");
    addv(32'hF0F0_0000, 5'd8,  2'b00, 32'hFFF0_F000, "sra_f0f0_b8");
    addv(32'h8000_0000, 5'd31, 2'b00, 32'hFFFF_FFFF, "sra_neg_b31");
    addv(32'h7FFF_FFFF, 5'd31, 2'b00, 32'h0000_0000, "sra_pos_b31");
    addv(32'hFFFF_FFFF, 5'd1,  2'b01, 32'h7FFF_FFFF, "srl_b1");
    addv(32'hFFFF_FFFF, 5'd4,  2'b01, 32'h0FFF_FFFF, "srl_b4");
    addv(32'hFFFF_FFFF, 5'd31, 2'b01, 32'h0000_0001, "srl_b31");
    addv(32'hFFFF_FFFF, 5'd0,  2'b01, 32'hFFFF_FFFF, "srl_b0");
    addv(32'hF0F0_0000, 5'd8,  2'b01, 32'h00F0_F000, "srl_f0f0_b8");
    addv(32'h1234_5678, 5'd16, 2'b01, 32'h0000_1234, "srl_b16");
    addv(32'hFFFF_FFFF, 5'd4,  2'b10, 32'hFFFF_FFF0, "sla_b4");
    addv(32'hFFFF_FFFF, 5'd31, 2'b10, 32'h8000_0000, "sla_b31");
    addv(32'h1234_5678, 5'd8,  2'b10, 32'h3456_7800, "sla_b8");
    addv(32'h1234_5678, 5'd0,  2'b10, 32'h1234_5678, "sla_b0");
    addv(32'hFFFF_FFFF, 5'd4,  2'b11, 32'hFFFF_FFF0, "sll_b4");
    addv(32'hFFFF_FFFF, 5'd31, 2'b11, 32'h8000_0000, "sll_b31");
    addv(32'h1234_5678, 5'd8,  2'b11, 32'h3456_7800, "sll_b8");
    addv(32'h1234_5678, 5'd16, 2'b11, 32'h5678_0000, "sll_b16");
    addv(32'h0000_0001, 5'd31, 2'b11, 32'h8000_0000, "sll_one_b31");

    // Asynchronous reset with no clock edge in between.
    drive(32'hFFFF_FFFF, 5'd5, 2'b00);
    #1 rst_n = 1'b0;
    #2 check("reset_async", bus.c, 32'h0);
    drive(32'hFFFF_FFFF, 5'd0, 2'b00);
    step();
    check("reset_held", bus.c, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("reset_release", bus.c, 32'hFFFF_FFFF);

    for (int i = 0; i < 32; i++) begin
      drive(32'hFFFF_FFFF, i[4:0], 2'b00);
      step();
      check($sformatf("sra_sweep_b%0d", i), bus.c, 32'hFFFF_FFFF);
    end

    for (int i = 0; i < 32; i++) begin
      drive(32'h0000_0001, i[4:0], 2'b11);
      step();
      check($sformatf("sll_walk_b%0d", i), bus.c, 32'h0000_0001 << i);
    end

    for (int i = 0; i < 32; i++) begin
      drive(32'h8000_0000, i[4:0], 2'b01);
      step();
      check($sformatf("srl_walk_b%0d", i), bus.c, 32'h8000_0000 >> i);
    end

    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].aluc);
      step();
      check(vecs[i].name, bus.c, vecs[i].exp);
    end

    // Mode changes every edge; c must still show the previous edge's result
    // until the next rising edge.
    begin
      logic [31:0] exp_seq [4];
      logic [31:0] prev;
      exp_seq[0] = 32'hC000_0000;
      exp_seq[1] = 32'h4000_0000;
      exp_seq[2] = 32'h0000_0002;
      exp_seq[3] = 32'h0000_0002;
      prev = 32'h0;
      for (int i = 0; i < 4; i++) begin
        drive(32'h8000_0001, 5'd1, i[1:0]);
        #1;
        if (i > 0) check($sformatf("b2b_hold_%0d", i), bus.c, prev);
        step();
        check($sformatf("b2b_mode_%0d", i), bus.c, exp_seq[i]);
        prev = exp_seq[i];
      end
    end

    // Reset pulse between edges during an SRL sweep.
    drive(32'hFFFF_FFFF, 5'd4, 2'b01);
    step();
    check("mid_pre", bus.c, 32'h0FFF_FFFF);
    drive(32'hFFFF_FFFF, 5'd1, 2'b01);
    #1 rst_n = 1'b0;
    #1 check("mid_async_clear", bus.c, 32'h0);
    #1 rst_n = 1'b1;
    #1 check("mid_after_release", bus.c, 32'h0);
    step();
    check("mid_resume", bus.c, 32'h7FFF_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
